// File: rtl/agc_pkg.sv
// agc_pkg: shared types and the gain step/clamp rule for agc_controller.
package agc_pkg;

   typedef logic signed [7:0] gain_t;

   typedef enum logic [2:0] {
      ST_ACCUM,
      ST_EVAL,
      ST_REQ,
      ST_ACK,
      ST_HOLD
   } agc_state_t;

   // New gain for one channel from its window peak. Thresholds are exclusive,
   // so a peak equal to either threshold keeps the gain. 9-bit signed
   // arithmetic so that g +/- step cannot wrap before clamping.
   function automatic gain_t next_gain(input gain_t       g,
                                       input logic [31:0] p,
                                       input int unsigned low_range,
                                       input int unsigned high_range,
                                       input int          gain_min,
                                       input int          gain_max,
                                       input int          gain_step);
      logic signed [8:0] g9;
      logic signed [8:0] n9;
      logic signed [8:0] lim;
      g9  = {g[7], g};
      n9  = g9;
      lim = g9;
      if (p > high_range) begin
         n9  = g9 - 9'(gain_step);
         lim = 9'(gain_min);
         if (n9 < lim) n9 = lim;
      end else if (p < low_range) begin
         n9  = g9 + 9'(gain_step);
         lim = 9'(gain_max);
         if (n9 > lim) n9 = lim;
      end
      return gain_t'(n9[7:0]);
   endfunction

endpackage

// File: rtl/agc_controller_if.sv
// agc_controller_if: ADC sample stream in, PGA gain-request handshake out.
// slave = controller side, master = environment side.
interface agc_controller_if
   import agc_pkg::*;
#(
   parameter int DW   = 16,
   parameter int N_CH = 2,
   parameter int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
);
   logic signed [DW-1:0] data_i;
   logic [CHW-1:0]       ch_i;
   logic                 valid_i;
   gain_t                gain_dB_o;
   logic [CHW-1:0]       gain_ch_o;
   logic                 set_gain_o;
   logic                 set_ready_i;
   logic                 busy_o;

   modport slave (
      input  data_i, ch_i, valid_i, set_ready_i,
      output gain_dB_o, gain_ch_o, set_gain_o, busy_o
   );

   modport master (
      output data_i, ch_i, valid_i, set_ready_i,
      input  gain_dB_o, gain_ch_o, set_gain_o, busy_o
   );
endinterface

// File: rtl/agc_controller_peak_tracker.sv
// peak_tracker: saturating |sample| and one running-max register per channel.
// A synchronous clear takes priority over an update in the same cycle.
module peak_tracker #(
   parameter int DW   = 16,
   parameter int N_CH = 2,
   parameter int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     upd,
   input  logic                     clr,
   input  logic [CHW-1:0]           ch,
   input  logic [DW-1:0]            data,
   output logic [N_CH-1:0][DW-1:0]  peak
);
   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

   logic [DW-1:0] mag;

   // magnitude with the most negative code saturated to the most positive
   always_comb begin
      mag = data;
      if (data == MOST_NEG)  mag = MOST_POS;
      else if (data[DW-1])   mag = ~data + 1'b1;
   end

   // per-channel running maximum
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         peak <= '0;
      end else if (clr) begin
         peak <= '0;
      end else if (upd) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch == CHW'(i) && mag > peak[i]) peak[i] <= mag;
         end
      end
   end
endmodule

// File: rtl/agc_controller.sv
// agc_controller: per-channel peak tracking over a sample window, then one
// gain adjustment per channel issued over a valid/ready request handshake.
// Optional feature macro: AGC_HOLDOFF_EN (discard HOLDOFF samples after a
// pass that committed at least one gain change).
module agc_controller
   import agc_pkg::*;
#(
   parameter int DW         = 16,
   parameter int N_CH       = 2,
   parameter int WIN_LEN    = 1024,
   parameter int LOW_RANGE  = 2048,
   parameter int HIGH_RANGE = 24576,
   parameter int GAIN_MIN   = -6,
   parameter int GAIN_MAX   = 40,
   parameter int GAIN_INIT  = 0,
   parameter int GAIN_STEP  = 3,
   parameter int HOLDOFF    = 256
) (
   input  logic            clk,
   input  logic            rst,
   agc_controller_if.slave bus
);
   localparam int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CNT_MAX = (WIN_LEN > HOLDOFF) ? WIN_LEN : HOLDOFF;
   localparam int CW      = $clog2(CNT_MAX + 1);

   agc_state_t              state_q, state_d;
   logic [CHW-1:0]          idx_q;
   logic [CW-1:0]           cnt_q;
   gain_t                   gain_q [N_CH];
   gain_t                   gain_dB_q;
   logic [CHW-1:0]          gain_ch_q;
   logic [N_CH-1:0][DW-1:0] peak;
   gain_t                   n_gain;
   logic acc, last, finish, busy, set_gain;
   logic cnt_inc, cnt_clr, idx_inc, idx_clr, load_req, commit;
`ifdef AGC_HOLDOFF_EN
   logic changed_q;
`endif

   assign acc  = bus.valid_i && (state_q == ST_ACCUM) && (32'(bus.ch_i) < 32'(N_CH));
   assign last = (32'(idx_q) == 32'(N_CH - 1));

   peak_tracker #(.DW(DW), .N_CH(N_CH), .CHW(CHW)) u_peak (
      .clk  (clk),
      .rst  (rst),
      .upd  (acc),
      .clr  (finish),
      .ch   (bus.ch_i),
      .data (bus.data_i),
      .peak (peak)
   );

   // proposed gain for the channel under evaluation
   always_comb begin
      n_gain = next_gain(gain_q[idx_q], 32'(peak[idx_q]), LOW_RANGE, HIGH_RANGE,
                         GAIN_MIN, GAIN_MAX, GAIN_STEP);
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_ACCUM;
      else      state_q <= state_d;
   end

   // next state and datapath controls; ST_ACK is the idle cycle after a
   // handshake that lets set_gain_o drop before the next channel is evaluated
   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      set_gain = 1'b0;
      cnt_inc  = 1'b0;
      cnt_clr  = 1'b0;
      idx_inc  = 1'b0;
      idx_clr  = 1'b0;
      load_req = 1'b0;
      commit   = 1'b0;
      finish   = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            if (acc) begin
               if (cnt_q == CW'(WIN_LEN - 1)) begin
                  cnt_clr = 1'b1;
                  idx_clr = 1'b1;
                  state_d = ST_EVAL;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         ST_EVAL: begin
            busy = 1'b1;
            if (n_gain != gain_q[idx_q]) begin
               load_req = 1'b1;
               state_d  = ST_REQ;
            end else if (last) begin
               finish = 1'b1;
            end else begin
               idx_inc = 1'b1;
            end
         end
         ST_REQ: begin
            busy     = 1'b1;
            set_gain = 1'b1;
            if (bus.set_ready_i) begin
               commit  = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            busy = 1'b1;
            if (last) begin
               finish = 1'b1;
            end else begin
               idx_inc = 1'b1;
               state_d = ST_EVAL;
            end
         end
`ifdef AGC_HOLDOFF_EN
         ST_HOLD: begin
            if (bus.valid_i) begin
               if (cnt_q == CW'(HOLDOFF - 1)) begin
                  cnt_clr = 1'b1;
                  state_d = ST_ACCUM;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
`endif
         default: state_d = ST_ACCUM;
      endcase
      if (finish) begin
`ifdef AGC_HOLDOFF_EN
         state_d = (changed_q && HOLDOFF > 0) ? ST_HOLD : ST_ACCUM;
`else
         state_d = ST_ACCUM;
`endif
      end
   end

   // counters, request registers and the committed gain register file
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q     <= '0;
         cnt_q     <= '0;
         gain_dB_q <= gain_t'(GAIN_INIT);
         gain_ch_q <= '0;
         for (int unsigned i = 0; i < N_CH; i++) gain_q[i] <= gain_t'(GAIN_INIT);
`ifdef AGC_HOLDOFF_EN
         changed_q <= 1'b0;
`endif
      end else begin
         if (cnt_clr)      cnt_q <= '0;
         else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
         if (idx_clr)      idx_q <= '0;
         else if (idx_inc) idx_q <= idx_q + 1'b1;
         if (load_req) begin
            gain_dB_q <= n_gain;
            gain_ch_q <= idx_q;
         end
         if (commit) gain_q[gain_ch_q] <= gain_dB_q;
`ifdef AGC_HOLDOFF_EN
         if (finish)      changed_q <= 1'b0;
         else if (commit) changed_q <= 1'b1;
`endif
      end
   end

   assign bus.set_gain_o = set_gain;
   assign bus.busy_o     = busy;
   assign bus.gain_dB_o  = gain_dB_q;
   assign bus.gain_ch_o  = gain_ch_q;
endmodule

// File: tb/tb_agc_controller.sv
// tb_agc_controller: randomized stimulus against a transaction-level model of
// the AGC (window peaks, gain rule, per-pass busy schedule, holdoff).
module tb_agc_controller;
   import agc_pkg::*;

   localparam int DW = 16, N_CH = 2, CHW = 1, WIN_LEN = 64;
   localparam int LOW_RANGE = 2048, HIGH_RANGE = 24576;
   localparam int GAIN_MIN = -6, GAIN_MAX = 40, GAIN_INIT = 0, GAIN_STEP = 3, HOLDOFF = 16;
`ifdef AGC_HOLDOFF_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   agc_controller_if #(.DW(DW), .N_CH(N_CH)) bus ();

   agc_controller #(
      .DW(DW), .N_CH(N_CH), .WIN_LEN(WIN_LEN), .LOW_RANGE(LOW_RANGE),
      .HIGH_RANGE(HIGH_RANGE), .GAIN_MIN(GAIN_MIN), .GAIN_MAX(GAIN_MAX),
      .GAIN_INIT(GAIN_INIT), .GAIN_STEP(GAIN_STEP), .HOLDOFF(HOLDOFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed { logic [7:0] ch; logic [7:0] gain; } req_t;
   typedef struct { int kind; int ch; int gain; } step_t;   // kind: 0 eval, 1 request, 2 post-ack

   int    m_gain [N_CH];
   int    m_peak [N_CH];
   int    m_cnt, m_hold, m_windows;
   bit    m_changed;
   step_t m_sched [$];
   req_t  exp_q [$];
   req_t  act_q [$];

   int    checks = 0, passes = 0;
   int    cyc_err, tmo, busy_seen, stall_cnt;
   string first_err;
   int    amp_lo [N_CH];
   int    amp_hi [N_CH];
   int    inj [N_CH];
   bit    inj_v [N_CH];
   int    vprob, ready_mode, stall_len;
   bit    busy_loud;

   function automatic int mag_of(int d);
      if (d < -32767) return 32767;
      return (d < 0) ? -d : d;
   endfunction

   function automatic int gain_rule(int g, int p);
      if (p > HIGH_RANGE) return (g - GAIN_STEP < GAIN_MIN) ? GAIN_MIN : g - GAIN_STEP;
      if (p < LOW_RANGE)  return (g + GAIN_STEP > GAIN_MAX) ? GAIN_MAX : g + GAIN_STEP;
      return g;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin m_gain[c] = GAIN_INIT; m_peak[c] = 0; inj_v[c] = 0; end
      m_cnt = 0; m_hold = 0; m_windows = 0; m_changed = 0;
      m_sched.delete(); exp_q.delete(); act_q.delete();
      cyc_err = 0; tmo = 0; busy_seen = 0; stall_cnt = 0; busy_loud = 0;
   endtask

   task automatic model_step(bit v, int ch, int d, bit rdy);
      step_t s;
      if (m_sched.size() > 0) begin
         s = m_sched[0];
         if (s.kind != 1 || rdy) begin
            if (s.kind == 1) begin
               m_gain[s.ch] = s.gain;
               exp_q.push_back(req_t'({8'(s.ch), 8'(s.gain)}));
               m_changed = 1;
            end
            void'(m_sched.pop_front());
            if (m_sched.size() == 0) begin
               if (HOLD_EN && m_changed) m_hold = HOLDOFF;
               m_changed = 0;
            end
         end
      end else if (m_hold > 0) begin
         if (v) m_hold--;
      end else if (v && ch < N_CH) begin
         if (mag_of(d) > m_peak[ch]) m_peak[ch] = mag_of(d);
         m_cnt++;
         if (m_cnt == WIN_LEN) begin
            m_cnt = 0;
            m_windows++;
            for (int c = 0; c < N_CH; c++) begin
               int n;
               n = gain_rule(m_gain[c], m_peak[c]);
               m_sched.push_back('{0, c, 0});
               if (n != m_gain[c]) begin
                  m_sched.push_back('{1, c, n});
                  m_sched.push_back('{2, c, 0});
               end
               m_peak[c] = 0;
            end
         end
      end
   endtask

   // one clock cycle: compare outputs with the model, drive inputs, advance both
   task automatic cycle();
      bit v, rdy, exp_busy, exp_set, ok_acc;
      int ch, d, sgn;
      exp_busy = (m_sched.size() > 0);
      exp_set  = exp_busy && (m_sched[0].kind == 1);
      if (bus.busy_o !== exp_busy || bus.set_gain_o !== exp_set ||
          (exp_set && (bus.gain_dB_o !== 8'(m_sched[0].gain) || bus.gain_ch_o !== CHW'(m_sched[0].ch)))) begin
         if (cyc_err == 0)
            first_err = $sformatf("t=%0t busy=%b/%b set=%b/%b gain=%0d ch=%0d", $time, bus.busy_o,
                                  exp_busy, bus.set_gain_o, exp_set, bus.gain_dB_o, bus.gain_ch_o);
         cyc_err++;
      end
      if (bus.busy_o === 1'b1) busy_seen++;
      v      = ($urandom_range(0, 99) < vprob);
      ch     = $urandom_range(0, N_CH - 1);
      sgn    = $urandom_range(0, 1) ? -1 : 1;
      ok_acc = v && m_sched.size() == 0 && m_hold == 0;
      if (m_hold > 0 || (exp_busy && busy_loud)) d = sgn * 32767;
      else if (ok_acc && inj_v[ch]) begin d = inj[ch]; inj_v[ch] = 0; end
      else d = sgn * $urandom_range(amp_lo[ch], amp_hi[ch]);
      case (ready_mode)
         0:       rdy = 1'b1;
         1:       rdy = $urandom_range(0, 1);
         2:       rdy = !(exp_set && stall_cnt < stall_len);
         default: rdy = 1'b0;
      endcase
      if (exp_set && !rdy) stall_cnt++;
      bus.valid_i = v; bus.ch_i = CHW'(ch); bus.data_i = 16'(d); bus.set_ready_i = rdy;
      if (bus.set_gain_o === 1'b1 && rdy) act_q.push_back(req_t'({8'(bus.gain_ch_o), bus.gain_dB_o}));
      model_step(v, ch, d, rdy);
      @(posedge clk); #1;
   endtask

   task automatic run_windows(int nwin);
      int target, n;
      target = m_windows + nwin;
      n = 0;
      while ((m_windows < target || m_sched.size() > 0 || m_hold > 0) && n < 20000) begin
         cycle();
         n++;
      end
      if (n >= 20000) tmo++;
   endtask

   task automatic set_amps(int lo0, int hi0, int lo1, int hi1);
      amp_lo[0] = lo0; amp_hi[0] = hi0; amp_lo[1] = lo1; amp_hi[1] = hi1;
   endtask

   task automatic reset_dut();
      bus.valid_i = 0; bus.ch_i = '0; bus.data_i = '0; bus.set_ready_i = 0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.set_gain_o !== 1'b0) $display("FAIL reset_set_gain got=%b want=0", bus.set_gain_o); else passes++;
      checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy_o); else passes++;
      checks++; if (bus.gain_dB_o !== 8'(GAIN_INIT)) $display("FAIL reset_gain_dB got=%0d want=%0d", bus.gain_dB_o, GAIN_INIT); else passes++;
      checks++; if (bus.gain_ch_o !== '0) $display("FAIL reset_gain_ch got=%0d want=0", bus.gain_ch_o); else passes++;
      reset_dut();
      set_amps(2048, 24576, 2048, 24576); vprob = 70; ready_mode = 1;
      run_windows(1);
      checks++; if (act_q.size() !== 0) $display("FAIL midrange_no_req got=%0d want=0", act_q.size()); else passes++;
      checks++; if (cyc_err !== 0 || tmo !== 0) $display("FAIL reset_cycles errs=%0d tmo=%0d first: %s", cyc_err, tmo, first_err); else passes++;
   endtask

   task automatic test_basic();
      reset_dut();
      set_amps(30000, 30000, 10000, 10000); vprob = 90; ready_mode = 0;
      run_windows(1);
      checks++; if (act_q.size() !== 1) $display("FAIL basic_req_count got=%0d want=1", act_q.size()); else passes++;
      if (act_q.size() > 0) begin
         checks++; if (act_q[0] !== req_t'({8'd0, 8'hFD})) $display("FAIL basic_req got=%h want=00fd", act_q[0]); else passes++;
      end
      checks++; if (busy_seen !== 4) $display("FAIL basic_dead_time got=%0d want=4", busy_seen); else passes++;
      checks++; if (cyc_err !== 0 || tmo !== 0) $display("FAIL basic_cycles errs=%0d tmo=%0d first: %s", cyc_err, tmo, first_err); else passes++;
   endtask

   task automatic test_ramp();
      reset_dut();
      set_amps(100, 100, 5000, 20000); vprob = 80; ready_mode = 1;
      run_windows(20);
      checks++; if (act_q.size() !== 14) $display("FAIL ramp_req_count got=%0d want=14", act_q.size()); else passes++;
      if (act_q.size() > 0) begin
         checks++; if (act_q[act_q.size()-1] !== req_t'({8'd0, 8'd40})) $display("FAIL ramp_last got=%h want=0028", act_q[act_q.size()-1]); else passes++;
      end
      checks++; if (act_q.size() !== exp_q.size()) $display("FAIL ramp_model_count got=%0d want=%0d", act_q.size(), exp_q.size()); else passes++;
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         checks++; if (act_q[i] !== exp_q[i]) $display("FAIL ramp_req[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); else passes++;
      end
      checks++; if (cyc_err !== 0 || tmo !== 0) $display("FAIL ramp_cycles errs=%0d tmo=%0d first: %s", cyc_err, tmo, first_err); else passes++;
   endtask

   task automatic test_boundary();
      reset_dut();
      vprob = 85; ready_mode = 0;
      set_amps(2048, 24576, 2048, 24575);
      inj[0] = -32768; inj_v[0] = 1; inj[1] = 24576; inj_v[1] = 1;
      run_windows(1);
      checks++; if (act_q.size() !== 1) $display("FAIL bnd_neg_full got=%0d want=1", act_q.size()); else passes++;
      if (act_q.size() > 0) begin
         checks++; if (act_q[0] !== req_t'({8'd0, 8'hFD})) $display("FAIL bnd_neg_req got=%h want=00fd", act_q[0]); else passes++;
      end
      set_amps(0, 2047, 2048, 24575);
      inj[0] = -2048; inj_v[0] = 1; inj[1] = -24576; inj_v[1] = 1;
      run_windows(1);
      checks++; if (act_q.size() !== 1) $display("FAIL bnd_equal_hold got=%0d want=1", act_q.size()); else passes++;
      checks++; if (cyc_err !== 0 || tmo !== 0) $display("FAIL bnd_cycles errs=%0d tmo=%0d first: %s", cyc_err, tmo, first_err); else passes++;
   endtask

   task automatic test_stall();
      reset_dut();
      set_amps(30000, 30000, 10000, 10000); vprob = 100; ready_mode = 2; stall_len = 50; busy_loud = 1;
      run_windows(1);
      checks++; if (busy_seen !== 54) $display("FAIL stall_dead_time got=%0d want=54", busy_seen); else passes++;
      checks++; if (act_q.size() !== 1) $display("FAIL stall_req_count got=%0d want=1", act_q.size()); else passes++;
      busy_loud = 0; set_amps(5000, 20000, 5000, 20000);
      run_windows(1);
      checks++; if (act_q.size() !== 1) $display("FAIL stall_drop got=%0d want=1", act_q.size()); else passes++;
      checks++; if (cyc_err !== 0 || tmo !== 0) $display("FAIL stall_cycles errs=%0d tmo=%0d first: %s", cyc_err, tmo, first_err); else passes++;
   endtask

   task automatic test_reset_in_req();
      int n;
      reset_dut();
      set_amps(30000, 30000, 10000, 10000); vprob = 90; ready_mode = 3;
      n = 0;
      while (stall_cnt < 5 && n < 2000) begin cycle(); n++; end
      checks++; if (bus.set_gain_o !== 1'b1) $display("FAIL rreq_pending got=%b want=1", bus.set_gain_o); else passes++;
      #2 rst = 1'b0;
      #1;
      checks++; if (bus.set_gain_o !== 1'b0) $display("FAIL rreq_drop got=%b want=0", bus.set_gain_o); else passes++;
      checks++; if (bus.gain_dB_o !== 8'(GAIN_INIT)) $display("FAIL rreq_gain_dB got=%0d want=%0d", bus.gain_dB_o, GAIN_INIT); else passes++;
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      ready_mode = 0;
      run_windows(1);
      checks++; if (act_q.size() !== 1) $display("FAIL rreq_after_count got=%0d want=1", act_q.size()); else passes++;
      if (act_q.size() > 0) begin
         checks++; if (act_q[0] !== req_t'({8'd0, 8'hFD})) $display("FAIL rreq_not_committed got=%h want=00fd", act_q[0]); else passes++;
      end
      checks++; if (cyc_err !== 0 || tmo !== 0 || n >= 2000) $display("FAIL rreq_cycles errs=%0d tmo=%0d n=%0d first: %s", cyc_err, tmo, n, first_err); else passes++;
   endtask

   task automatic test_back_to_back();
      int lo [3];
      int hi [3];
      int k0, k1;
      lo = '{0, 2048, 24577}; hi = '{2047, 24576, 32767};
      reset_dut();
      vprob = 60; ready_mode = 1;
      for (int w = 0; w < 10; w++) begin
         k0 = $urandom_range(0, 2); k1 = $urandom_range(0, 2);
         set_amps(lo[k0], hi[k0], lo[k1], hi[k1]);
         run_windows(1);
      end
      checks++; if (act_q.size() !== exp_q.size()) $display("FAIL b2b_count got=%0d want=%0d", act_q.size(), exp_q.size()); else passes++;
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         checks++; if (act_q[i] !== exp_q[i]) $display("FAIL b2b_req[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); else passes++;
      end
      checks++; if (cyc_err !== 0 || tmo !== 0) $display("FAIL b2b_cycles errs=%0d tmo=%0d first: %s", cyc_err, tmo, first_err); else passes++;
   endtask

`ifdef AGC_HOLDOFF_EN
   task automatic test_holdoff();
      reset_dut();
      set_amps(30000, 30000, 10000, 10000); vprob = 90; ready_mode = 0;
      run_windows(1);
      checks++; if (act_q.size() !== 1) $display("FAIL hold_first got=%0d want=1", act_q.size()); else passes++;
      set_amps(10000, 10000, 10000, 10000);
      run_windows(1);
      checks++; if (act_q.size() !== 1) $display("FAIL hold_ignored got=%0d want=1", act_q.size()); else passes++;
      checks++; if (cyc_err !== 0 || tmo !== 0) $display("FAIL hold_cycles errs=%0d tmo=%0d first: %s", cyc_err, tmo, first_err); else passes++;
   endtask
`endif

   initial begin
      #200000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.valid_i = 0; bus.ch_i = '0; bus.data_i = '0; bus.set_ready_i = 0;
      model_reset();
      set_amps(0, 0, 0, 0);
      #2;
      test_reset();
      test_basic();
      test_ramp();
      test_boundary();
      test_stall();
      test_reset_in_req();
      test_back_to_back();
`ifdef AGC_HOLDOFF_EN
      test_holdoff();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/agc_controller.md
# agc_controller

Multi-channel automatic gain controller: tracks per-channel peak magnitude of the ADC sample stream over a fixed evaluation window, then steps each channel's PGA gain up or down with hysteresis and clamping. Issues gain changes one channel at a time over a valid/ready handshake to the PGA programming interface. It sits between the ADC sample stream and the PGA driver.

## Interface
- DW, 16: sample width, signed two's complement
- N_CH, 2: channel count (≥1); CHW = max(1, $clog2(N_CH))
- WIN_LEN, 1024: accepted samples (all channels combined) per evaluation window (≥2)
- LOW_RANGE, 2048: peak magnitude below which gain is raised
- HIGH_RANGE, 24576: peak magnitude above which gain is lowered (LOW_RANGE < HIGH_RANGE < 2^(DW-1))
- GAIN_MIN, -6 / GAIN_MAX, 40 / GAIN_INIT, 0: gain limits and reset gain in dB (signed 8-bit, MIN ≤ INIT ≤ MAX)
- GAIN_STEP, 3: dB per adjustment (1..31)
- HOLDOFF, 256: settling samples discarded after a gain change (only with AGC_HOLDOFF_EN)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- data_i  in  DW  signed sample
- ch_i  in  CHW  channel tag of data_i; values ≥ N_CH are ignored
- valid_i  in  1  data_i/ch_i qualifier
- gain_dB_o  out  8  signed requested gain for gain_ch_o
- gain_ch_o  out  CHW  channel of the request
- set_gain_o  out  1  request valid
- set_ready_i  in  1  PGA driver accepts request
- busy_o  out  1  high in EVAL/REQ (samples dropped)

## Operation
- States: ACCUM, EVAL, REQ (plus HOLD with AGC_HOLDOFF_EN). Reset → ACCUM.
- ACCUM: on each valid_i with ch_i < N_CH: mag = |data_i|, saturated so that -2^(DW-1) → 2^(DW-1)-1; peak[ch] = max(peak[ch], mag); win_cnt++. A sample with ch_i ≥ N_CH is not counted. On the sample making win_cnt = WIN_LEN → EVAL with idx = 0, win_cnt = 0.
- EVAL (one cycle per channel): p = peak[idx], g = gain[idx]. If p > HIGH_RANGE: n = max(g − GAIN_STEP, GAIN_MIN). Else if p < LOW_RANGE: n = min(g + GAIN_STEP, GAIN_MAX). Else n = g. Equality with either threshold holds the gain. Arithmetic is done in 9-bit signed; no wrap.
  - n ≠ g → REQ (register gain_dB_o = n, gain_ch_o = idx).
  - n = g → idx++, or finish if idx = N_CH−1.
- REQ: set_gain_o = 1; gain_dB_o and gain_ch_o stable until set_ready_i. On the handshake cycle: gain[idx] = n, set changed flag, drop set_gain_o next cycle, then idx++ → EVAL, or finish.
- Finish: clear all peak[] to 0. Go to HOLD if changed and AGC_HOLDOFF_EN, else ACCUM.
- Samples with valid_i during EVAL/REQ are dropped: no peak update and no count.
- Reset: all peak = 0, gain[] = GAIN_INIT, win_cnt = 0, idx = 0. Outputs: set_gain_o = 0, gain_dB_o = GAIN_INIT, gain_ch_o = 0, busy_o = 0.
- No request is issued at reset. The PGA driver powers up at GAIN_INIT.

## Timing
- The last window sample is accepted in cycle t. EVAL for ch0 runs in t+1. If ch0 changes, set_gain_o is high from t+2.
- Each unchanged channel costs 1 cycle. Each changed channel costs 1 EVAL cycle + REQ cycles (≥1) + 1.
- set_gain_o never deasserts without set_ready_i. set_ready_i while set_gain_o = 0 is ignored.
- Worst-case dead time with zero-wait ready: 3·N_CH cycles.
- Asserting rst mid-REQ immediately drops set_gain_o. The pending gain is not committed.

## Configuration
- AGC_HOLDOFF_EN defined: after a pass with ≥1 committed change, enter HOLD. Discard the next HOLDOFF valid samples (any channel): no peak update and no count, busy_o = 0. Then enter ACCUM.
- AGC_HOLDOFF_EN undefined: no HOLD state. Accumulation restarts the cycle after finish.

## Structure
- agc_pkg: state enum, gain_t (logic signed [7:0]), clamp/step function producing n from (g, p, thresholds, limits).
- Sub-module peak_tracker: saturating abs plus per-channel max registers with sync clear. Parametrised DW, N_CH.
- Top: window/holdoff counters, FSM, gain register file.

## Test plan
- N_CH=2, ch0 samples ±30000, ch1 ±10000 for one window → one request ch0 gain 0→−3; ch1 no request; 4 EVAL/REQ cycles with ready tied high.
- ch0 constant amplitude 100 for 20 windows → gain rises 3,6,…,39,40, then no further requests at 40.
- Sample −32768 (DW=16) → mag 32767 > HIGH_RANGE → gain lowered. Peak exactly 24576 or exactly 2048 → no request.
- Hold set_ready_i low 50 cycles in REQ → set_gain_o, gain_dB_o, gain_ch_o stable; samples during REQ do not affect the next window.
- Assert rst during REQ → set_gain_o = 0 in the same cycle; gains read GAIN_INIT afterward.
- AGC_HOLDOFF_EN: after a change, the first 256 samples at ±32767 are ignored; the next window at ±10000 → no request.
